// File: rtl/tlc_pkg.sv
// Shared constants for the multi-approach traffic light controller: phase one-hot
// codes, lamp encodings and the phase-timer width helper.
package tlc_pkg;

  localparam logic [3:0] PH_GREEN  = 4'b0001;
  localparam logic [3:0] PH_YELLOW = 4'b0010;
  localparam logic [3:0] PH_ALLRED = 4'b0100;
  localparam logic [3:0] PH_WALK   = 4'b1000;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  // The timer only ever counts up to (longest phase - 1), so clog2 of the longest phase suffices.
  function automatic int timer_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/tlc_rr_arbiter.sv
// Combinational round-robin finder: first set req bit after ptr, scanning
// ptr+1 .. ptr+NUM_DIR-1 with wrap-around; ptr itself is never selected.
module tlc_rr_arbiter
  import tlc_pkg::*;
#(
  parameter int NUM_DIR = 4
) (
  input  logic [NUM_DIR-1:0]         req,
  input  logic [$clog2(NUM_DIR)-1:0] ptr,
  output logic [$clog2(NUM_DIR)-1:0] next_dir,
  output logic                       valid
);

  localparam int DW = $clog2(NUM_DIR);

  int idx;

  // Scan from the far end back toward ptr so the nearest requester wins.
  always_comb begin
    next_dir = '0;
    valid    = 1'b0;
    idx      = 0;
    for (int k = NUM_DIR - 1; k >= 1; k--) begin
      idx = (int'(ptr) + k) % NUM_DIR;
      if (req[idx]) begin
        next_dir = DW'(idx);
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tlc_multiway.sv
// N-approach traffic light controller: round-robin green with min/max timing, yellow,
// all-red clearance. Optional pedestrian walk phase enabled by defining TLC_PED_WALK_EN.
module tlc_multiway
  import tlc_pkg::*;
#(
  parameter int NUM_DIR     = 4,
  parameter int GREEN_MIN   = 4,
  parameter int GREEN_MAX   = 12,
  parameter int YELLOW_TIME = 2,
  parameter int ALLRED_TIME = 1,
  parameter int WALK_TIME   = 6
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_DIR-1:0]         car,
`ifdef TLC_PED_WALK_EN
  input  logic                       ped_req,
  output logic                       walk,
`endif
  output logic [3*NUM_DIR-1:0]       lights,
  output logic [$clog2(NUM_DIR)-1:0] active_dir,
  output logic [3:0]                 phase
);

  localparam int DW = $clog2(NUM_DIR);
  localparam int TW = timer_width(GREEN_MAX, YELLOW_TIME, ALLRED_TIME, WALK_TIME);

  localparam logic [TW-1:0] G_MIN_LAST  = TW'(GREEN_MIN - 1);
  localparam logic [TW-1:0] G_MAX_LAST  = TW'(GREEN_MAX - 1);
  localparam logic [TW-1:0] Y_LAST      = TW'(YELLOW_TIME - 1);
  localparam logic [TW-1:0] AR_LAST     = TW'(ALLRED_TIME - 1);
  localparam logic [3*NUM_DIR-1:0] RESET_LIGHTS = {{(NUM_DIR-1){LAMP_RED}}, LAMP_GRN};

  logic [3:0]           state, state_nxt;
  logic [DW-1:0]        dir_nxt, rr_next;
  logic                 rr_valid;
  logic [TW-1:0]        timer;
  logic [NUM_DIR-1:0]   req, pend, other, clr;
  logic [3*NUM_DIR-1:0] lights_nxt;
  logic                 ped_now, green_exit;

  assign phase = state;

`ifdef TLC_PED_WALK_EN
  localparam logic [TW-1:0] W_LAST = TW'(WALK_TIME - 1);
  logic ped_pend;
  assign ped_now = ped_pend | ped_req;
`else
  assign ped_now = 1'b0;
`endif

  // A same-cycle arrival counts as pending; the active approach is never "other".
  always_comb begin
    pend             = req | car;
    other            = pend;
    other[active_dir] = 1'b0;
  end

  assign green_exit = ((|other) || ped_now) &&
                      ((!car[active_dir] && timer >= G_MIN_LAST) || timer >= G_MAX_LAST);

  tlc_rr_arbiter #(.NUM_DIR(NUM_DIR)) u_rr (
    .req      (pend),
    .ptr      (active_dir),
    .next_dir (rr_next),
    .valid    (rr_valid)
  );

  always_comb begin
    state_nxt = state;
    dir_nxt   = active_dir;
    case (state)
      PH_GREEN:  if (green_exit) state_nxt = PH_YELLOW;
      PH_YELLOW: if (timer == Y_LAST) state_nxt = PH_ALLRED;
      PH_ALLRED: begin
        if (timer == AR_LAST) begin
          if (ped_now) begin
            state_nxt = PH_WALK;
          end else begin
            state_nxt = PH_GREEN;
            if (rr_valid) dir_nxt = rr_next;
          end
        end
      end
`ifdef TLC_PED_WALK_EN
      PH_WALK: begin
        if (timer == W_LAST) begin
          state_nxt = PH_GREEN;
          if (rr_valid) dir_nxt = rr_next;
        end
      end
`endif
      default: begin
        state_nxt = PH_GREEN;
        dir_nxt   = '0;
      end
    endcase
  end

  // Lamps are computed from the next state so they register on the same edge.
  always_comb begin
    clr        = '0;
    lights_nxt = {NUM_DIR{LAMP_RED}};
    if (state_nxt == PH_GREEN && state != PH_GREEN) clr[dir_nxt] = 1'b1;
    for (int i = 0; i < NUM_DIR; i++) begin
      if (DW'(i) == dir_nxt) begin
        if (state_nxt == PH_GREEN)       lights_nxt[3*i +: 3] = LAMP_GRN;
        else if (state_nxt == PH_YELLOW) lights_nxt[3*i +: 3] = LAMP_YEL;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= PH_GREEN;
      active_dir <= '0;
      timer      <= '0;
      req        <= '0;
      lights     <= RESET_LIGHTS;
`ifdef TLC_PED_WALK_EN
      ped_pend   <= 1'b0;
      walk       <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      active_dir <= dir_nxt;
      req        <= (req | car) & ~clr;
      lights     <= lights_nxt;
      if (state_nxt != state) timer <= '0;
      else if (state != PH_GREEN || timer < G_MAX_LAST) timer <= timer + 1'b1;
`ifdef TLC_PED_WALK_EN
      ped_pend   <= ped_now & ~(state_nxt == PH_WALK && state != PH_WALK);
      walk       <= (state_nxt == PH_WALK);
`endif
    end
  end

endmodule

// File: tb/tb_tlc_multiway.sv
// Directed, table-driven bench for tlc_multiway with default parameters.
// Exercises the walk phase too when TLC_PED_WALK_EN is defined.
module tb_tlc_multiway;

  localparam logic [11:0] G0 = 12'b100_100_100_001;
  localparam logic [11:0] Y0 = 12'b100_100_100_010;
  localparam logic [11:0] G1 = 12'b100_100_001_100;
  localparam logic [11:0] Y1 = 12'b100_100_010_100;
  localparam logic [11:0] G2 = 12'b100_001_100_100;
  localparam logic [11:0] G3 = 12'b001_100_100_100;
  localparam logic [11:0] AR = 12'b100_100_100_100;
  localparam logic [3:0]  PG = 4'b0001;
  localparam logic [3:0]  PY = 4'b0010;
  localparam logic [3:0]  PR = 4'b0100;
  localparam logic [3:0]  PW = 4'b1000;

  typedef struct {
    logic        rst;
    logic [3:0]  car;
    logic [11:0] lights;
    logic [3:0]  phase;
    logic [1:0]  dir;
  } vec_t;

  logic        clk;
  logic        reset;
  logic [3:0]  car;
  logic [11:0] lights;
  logic [1:0]  active_dir;
  logic [3:0]  phase;
`ifdef TLC_PED_WALK_EN
  logic        ped_req;
  logic        walk;
`endif

  int   checks   = 0;
  int   failures = 0;
  vec_t vecs[$];

  tlc_multiway dut (
    .clk        (clk),
    .reset      (reset),
    .car        (car),
`ifdef TLC_PED_WALK_EN
    .ped_req    (ped_req),
    .walk       (walk),
`endif
    .lights     (lights),
    .active_dir (active_dir),
    .phase      (phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [11:0] el,
                             input logic [3:0] ep, input logic [1:0] ed);
    checks++;
    if (lights !== el || phase !== ep || active_dir !== ed) begin
      failures++;
      $display("[TB] FAIL %s: got lights=%b phase=%b dir=%0d, expected lights=%b phase=%b dir=%0d",
               name, lights, phase, active_dir, el, ep, ed);
    end
  endtask

  // Drive the inputs for the next edge, then sample just after it.
  task automatic applyStimulus(input logic [3:0] c);
    car = c;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b0;
    car   = '0;
`ifdef TLC_PED_WALK_EN
    ped_req = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_state", G0, PG, 2'd0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic addVec(input logic r, input logic [3:0] c, input logic [11:0] l,
                        input logic [3:0] p, input logic [1:0] d);
    vec_t v;
    v.rst = r; v.car = c; v.lights = l; v.phase = p; v.dir = d;
    vecs.push_back(v);
  endtask

  initial begin
    reset = 1'b0;
    car   = '0;
`ifdef TLC_PED_WALK_EN
    ped_req = 1'b0;
`endif

    // Single request on dir2 arriving after dir0 has been green one cycle.
    addVec(1, 4'b0000, G0, PG, 0);
    addVec(0, 4'b0100, G0, PG, 0);
    addVec(0, 4'b0000, G0, PG, 0);
    addVec(0, 4'b0000, Y0, PY, 0);
    addVec(0, 4'b0000, Y0, PY, 0);
    addVec(0, 4'b0000, AR, PR, 0);
    for (int i = 0; i < 5; i++) addVec(0, 4'b0000, G2, PG, 2);
    // Simultaneous dir1/dir3 requests: dir1 first, dir3 next, dir2 skipped.
    addVec(1, 4'b0000, G0, PG, 0);
    addVec(0, 4'b1010, G0, PG, 0);
    addVec(0, 4'b0000, G0, PG, 0);
    addVec(0, 4'b0000, Y0, PY, 0);
    addVec(0, 4'b0000, Y0, PY, 0);
    addVec(0, 4'b0000, AR, PR, 0);
    for (int i = 0; i < 4; i++) addVec(0, 4'b0000, G1, PG, 1);
    addVec(0, 4'b0000, Y1, PY, 1);
    addVec(0, 4'b0000, Y1, PY, 1);
    addVec(0, 4'b0000, AR, PR, 1);
    for (int i = 0; i < 6; i++) addVec(0, 4'b0000, G3, PG, 3);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) doReset();
      applyStimulus(vecs[i].car);
      checkOutput($sformatf("vec%0d", i), vecs[i].lights, vecs[i].phase, vecs[i].dir);
    end

    // Idle: dir0 green forever with no requests.
    doReset();
    for (int k = 0; k < 50; k++) begin
      applyStimulus(4'b0000);
      checkOutput($sformatf("idle%0d", k), G0, PG, 2'd0);
    end

    // dir0 held busy: contested green ends only at GREEN_MAX.
    doReset();
    for (int k = 0; k < 18; k++) begin
      applyStimulus((k == 0) ? 4'b0011 : 4'b0001);
      if (k <= 10)      checkOutput($sformatf("max%0d", k), G0, PG, 2'd0);
      else if (k <= 12) checkOutput($sformatf("max%0d", k), Y0, PY, 2'd0);
      else if (k == 13) checkOutput($sformatf("max%0d", k), AR, PR, 2'd0);
      else              checkOutput($sformatf("max%0d", k), G1, PG, 2'd1);
    end

    // Reset asserted mid-yellow discards latched requests.
    doReset();
    applyStimulus(4'b0000);
    applyStimulus(4'b0110);
    applyStimulus(4'b0000);
    applyStimulus(4'b0000);
    checkOutput("pre_rst_yellow", Y0, PY, 2'd0);
    #3 reset = 1'b0;
    #1 checkOutput("async_reset", G0, PG, 2'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 20; k++) begin
      applyStimulus(4'b0000);
      checkOutput($sformatf("post_rst%0d", k), G0, PG, 2'd0);
    end

`ifdef TLC_PED_WALK_EN
    // Pedestrian request served between dir0 and dir1.
    doReset();
    ped_req = 1'b1;
    applyStimulus(4'b0010);
    ped_req = 1'b0;
    checkOutput("walk0", G0, PG, 2'd0);
    for (int k = 1; k <= 12; k++) begin
      applyStimulus(4'b0000);
      if (k <= 2)       checkOutput($sformatf("walk%0d", k), G0, PG, 2'd0);
      else if (k <= 4)  checkOutput($sformatf("walk%0d", k), Y0, PY, 2'd0);
      else if (k == 5)  checkOutput($sformatf("walk%0d", k), AR, PR, 2'd0);
      else if (k <= 11) checkOutput($sformatf("walk%0d", k), AR, PW, 2'd0);
      else              checkOutput($sformatf("walk%0d", k), G1, PG, 2'd1);
      checks++;
      if (walk !== (k >= 6 && k <= 11)) begin
        failures++;
        $display("[TB] FAIL walk_lamp%0d: got %b expected %b", k, walk, (k >= 6 && k <= 11));
      end
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
